// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// One 40-bit adder/shift-accumulator shared between the left and right ALU
// sequencers. Each channel keeps its own accumulator and sticky overflow flag;
// a round-robin arbiter with lockable, length-limited bursts decides which
// channel's op goes through the shared datapath on each Sclk edge.
module alu_share_arbiter #(
   parameter int WIDTH     = 40,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 5
) (
   input  logic             Sclk,
   input  logic             Reset_n,
   input  logic             Clear,
   input  logic             req_L,
   input  logic [2:0]       op_L,
   input  logic [WIDTH-1:0] opnd_L,
   input  logic             lock_L,
   input  logic             req_R,
   input  logic [2:0]       op_R,
   input  logic [WIDTH-1:0] opnd_R,
   input  logic             lock_R,
   output logic             gnt_L,
   output logic             gnt_R,
   output logic [WIDTH-1:0] acc_L,
   output logic [WIDTH-1:0] acc_R,
   output logic             ovf_L,
   output logic             ovf_R,
   output logic [1:0]       owner
);

   // Ownership states, also driven straight out on the owner port.
   localparam logic [1:0] OWN_IDLE = 2'b00;
   localparam logic [1:0] OWN_L    = 2'b01;
   localparam logic [1:0] OWN_R    = 2'b10;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_CLR  = 3'b011;
   localparam logic [2:0] OP_LOAD = 3'b100;

   localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

   logic [1:0]       ownerQ, ownerD;
   logic             prioR, prioD;      // 1: right channel wins the next tie
   logic [CNT_W-1:0] burstCnt, cntD;
   logic [WIDTH-1:0] accL, accR;
   logic             ovfL, ovfR;

   logic             grantL, grantR;
   logic             viaIdle;           // grant decided by the IDLE rules
   logic             atMax;

   logic [2:0]       aluOp;
   logic [WIDTH-1:0] aluOpnd, aluAcc, aluSum, aluDiff, resAcc;
   logic             aluOvf, resOvf;

   assign atMax = (burstCnt == BURST_CAP);

   // Arbitration: who owns the shared datapath on the coming edge.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      grantL  = 1'b0;
      grantR  = 1'b0;
      viaIdle = 1'b0;
      case (ownerQ)
         OWN_L: begin
            if (req_L && !(atMax && req_R)) begin
               grantL = 1'b1;
            end else begin
               // Owner dropped or was forced out: only the right side can win.
               grantR  = req_R;
               viaIdle = 1'b1;
            end
         end
         OWN_R: begin
            if (req_R && !(atMax && req_L)) begin
               grantR = 1'b1;
            end else begin
               grantL  = req_L;
               viaIdle = 1'b1;
            end
         end
         default: begin
            viaIdle = 1'b1;
            if (req_L && req_R) begin
               grantL = !prioR;
               grantR = prioR;
            end else begin
               grantL = req_L;
               grantR = req_R;
            end
         end
      endcase
      // NOTE: grants are combinational, so they are gated by the async reset as well as Clear.
      if (Clear || !Reset_n) begin
         grantL = 1'b0;
         grantR = 1'b0;
      end
   end

   // Next ownership, priority pointer and burst count after this cycle's grant.
   always_comb begin
      ownerD = ownerQ;
      prioD  = prioR;
      cntD   = burstCnt;
      if (grantL || grantR) begin
         prioD = grantL;                // pointer moves to the channel not served
         if (!(grantL ? lock_L : lock_R)) begin
            ownerD = OWN_IDLE;
            cntD   = '0;
         end else if (viaIdle) begin
            ownerD = grantL ? OWN_L : OWN_R;
            cntD   = CNT_W'(1);
         end else if (!atMax) begin
            cntD = burstCnt + CNT_W'(1);
         end
      end else begin
         ownerD = OWN_IDLE;
         cntD   = '0;
      end
   end

   // Shared datapath: operands steered from the granted channel.
   always_comb begin
      aluOp   = grantR ? op_R   : op_L;
      aluOpnd = grantR ? opnd_R : opnd_L;
      aluAcc  = grantR ? accR   : accL;
      aluOvf  = grantR ? ovfR   : ovfL;
      aluSum  = aluAcc + aluOpnd;
      aluDiff = aluAcc - aluOpnd;
      resAcc  = aluAcc;
      resOvf  = aluOvf;
      case (aluOp)
         OP_ADD: begin
            resAcc = aluSum;
            resOvf = aluOvf | ((aluAcc[WIDTH-1] == aluOpnd[WIDTH-1]) &&
                               (aluSum[WIDTH-1] != aluAcc[WIDTH-1]));
         end
         OP_SUB: begin
            // Effective second operand is -opnd, so its sign is inverted.
            resAcc = aluDiff;
            resOvf = aluOvf | ((aluAcc[WIDTH-1] != aluOpnd[WIDTH-1]) &&
                               (aluDiff[WIDTH-1] != aluAcc[WIDTH-1]));
         end
         OP_SHR:  resAcc = {aluAcc[WIDTH-1], aluAcc[WIDTH-1:1]};
         OP_CLR: begin
            resAcc = '0;
            resOvf = 1'b0;
         end
         OP_LOAD: resAcc = aluOpnd;
         default: ;                     // NOP: granted, nothing changes
      endcase
   end

   // State registers: arbiter state plus both accumulator contexts.
   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         ownerQ   <= OWN_IDLE;
         prioR    <= 1'b0;
         burstCnt <= '0;
         accL     <= '0;
         accR     <= '0;
         ovfL     <= 1'b0;
         ovfR     <= 1'b0;
      end else if (Clear) begin
         ownerQ   <= OWN_IDLE;
         prioR    <= 1'b0;
         burstCnt <= '0;
         accL     <= '0;
         accR     <= '0;
         ovfL     <= 1'b0;
         ovfR     <= 1'b0;
      end else begin
         // NOTE: registered state uses non-blocking assignments so all flops update together.
         ownerQ   <= ownerD;
         prioR    <= prioD;
         burstCnt <= cntD;
         if (grantL) begin
            accL <= resAcc;
            ovfL <= resOvf;
         end
         if (grantR) begin
            accR <= resAcc;
            ovfR <= resOvf;
         end
      end
   end

   assign gnt_L = grantL;
   assign gnt_R = grantR;
   assign acc_L = accL;
   assign acc_R = accR;
   assign ovf_L = ovfL;
   assign ovf_R = ovfR;
   assign owner = ownerQ;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Directed bench: inputs change on the falling edge, grants are sampled 1 ns
// later, registered outputs 1 ns after the rising edge.
module tb_alu_share_arbiter;

   localparam int WIDTH = 40;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_CLR  = 3'b011;
   localparam logic [2:0] OP_LOAD = 3'b100;
   localparam logic [2:0] OP_NOP  = 3'b101;

   logic             Sclk;
   logic             Reset_n;
   logic             Clear;
   logic             req_L, lock_L, req_R, lock_R;
   logic [2:0]       op_L, op_R;
   logic [WIDTH-1:0] opnd_L, opnd_R;
   logic             gnt_L, gnt_R, ovf_L, ovf_R;
   logic [WIDTH-1:0] acc_L, acc_R;
   logic [1:0]       owner;

   int checks   = 0;
   int failures = 0;

   alu_share_arbiter #(.WIDTH(WIDTH), .MAX_BURST(16), .CNT_W(5)) dut (
      .Sclk(Sclk), .Reset_n(Reset_n), .Clear(Clear),
      .req_L(req_L), .op_L(op_L), .opnd_L(opnd_L), .lock_L(lock_L),
      .req_R(req_R), .op_R(op_R), .opnd_R(opnd_R), .lock_R(lock_R),
      .gnt_L(gnt_L), .gnt_R(gnt_R), .acc_L(acc_L), .acc_R(acc_R),
      .ovf_L(ovf_L), .ovf_R(ovf_R), .owner(owner)
   );

   initial Sclk = 1'b0;
   always #5 Sclk = ~Sclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic setL(input logic req, input logic [2:0] op, input logic [WIDTH-1:0] opnd, input logic lock);
      req_L = req; op_L = op; opnd_L = opnd; lock_L = lock;
   endtask

   task automatic setR(input logic req, input logic [2:0] op, input logic [WIDTH-1:0] opnd, input logic lock);
      req_R = req; op_R = op; opnd_R = opnd; lock_R = lock;
   endtask

   task automatic afterRise;
      @(posedge Sclk);
      #1;
   endtask

   initial begin
      // Reset with a left request pending: grants must stay low.
      Reset_n = 1'b0;
      Clear   = 1'b0;
      setL(1'b1, OP_NOP, '0, 1'b0);
      setR(1'b0, OP_NOP, '0, 1'b0);
      repeat (2) @(posedge Sclk);
      #1;
      check("rst_gnt_L", 64'(gnt_L), 64'h0);
      check("rst_gnt_R", 64'(gnt_R), 64'h0);
      check("rst_acc_L", 64'(acc_L), 64'h0);
      check("rst_acc_R", 64'(acc_R), 64'h0);
      check("rst_ovf_L", 64'(ovf_L), 64'h0);
      check("rst_ovf_R", 64'(ovf_R), 64'h0);
      check("rst_owner", 64'(owner), 64'h0);

      // LOAD then ADD on the left channel.
      @(negedge Sclk);
      Reset_n = 1'b1;
      setL(1'b1, OP_LOAD, 40'h00_0001_0000, 1'b0);
      #1;
      check("load_gnt_L", 64'(gnt_L), 64'h1);
      check("load_gnt_R", 64'(gnt_R), 64'h0);
      afterRise();
      check("load_acc_L", 64'(acc_L), 64'h00_0001_0000);
      @(negedge Sclk);
      setL(1'b1, OP_ADD, 40'h00_0002_0000, 1'b0);
      #1;
      check("add_gnt_L", 64'(gnt_L), 64'h1);
      afterRise();
      check("add_acc_L", 64'(acc_L), 64'h00_0003_0000);
      check("add_acc_R", 64'(acc_R), 64'h0);

      // Clear beats a pending request and restores pointer=L.
      @(negedge Sclk);
      Clear = 1'b1;
      setL(1'b1, OP_NOP, '0, 1'b0);
      #1;
      check("clr_gnt_L", 64'(gnt_L), 64'h0);
      check("clr_gnt_R", 64'(gnt_R), 64'h0);
      afterRise();
      check("clr_acc_L", 64'(acc_L), 64'h0);
      check("clr_owner", 64'(owner), 64'h0);

      // Both channels request without lock: strict alternation starting at L.
      @(negedge Sclk);
      Clear = 1'b0;
      setL(1'b1, OP_NOP, '0, 1'b0);
      setR(1'b1, OP_NOP, '0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge Sclk);
         #1;
         check($sformatf("alt%0d_gnt_L", i), 64'(gnt_L), (i % 2 == 0) ? 64'h1 : 64'h0);
         check($sformatf("alt%0d_gnt_R", i), 64'(gnt_R), (i % 2 == 1) ? 64'h1 : 64'h0);
      end

      // Right channel: signed overflow on ADD, then CLR.
      @(negedge Sclk);
      setL(1'b0, OP_NOP, '0, 1'b0);
      setR(1'b1, OP_LOAD, 40'h7F_FFFF_FFFF, 1'b0);
      #1;
      check("ldR_gnt_R", 64'(gnt_R), 64'h1);
      @(negedge Sclk);
      setR(1'b1, OP_ADD, 40'h1, 1'b0);
      afterRise();
      check("ovf_acc_R", 64'(acc_R), 64'h80_0000_0000);
      check("ovf_ovf_R", 64'(ovf_R), 64'h1);
      check("ovf_ovf_L", 64'(ovf_L), 64'h0);
      @(negedge Sclk);
      setR(1'b1, OP_CLR, '0, 1'b0);
      afterRise();
      check("clrop_acc_R", 64'(acc_R), 64'h0);
      check("clrop_ovf_R", 64'(ovf_R), 64'h0);

      // SUB going negative without overflow: 5 - 7 = -2.
      @(negedge Sclk);
      setR(1'b1, OP_LOAD, 40'h5, 1'b0);
      @(negedge Sclk);
      setR(1'b1, OP_SUB, 40'h7, 1'b0);
      afterRise();
      check("sub_acc_R", 64'(acc_R), 64'hFF_FFFF_FFFE);
      check("sub_ovf_R", 64'(ovf_R), 64'h0);

      // Left arithmetic shift keeps the sign; NOP opcode leaves it alone.
      @(negedge Sclk);
      setR(1'b0, OP_NOP, '0, 1'b0);
      setL(1'b1, OP_LOAD, 40'hFF_FFFF_FFF8, 1'b0);
      @(negedge Sclk);
      setL(1'b1, OP_SHR, '0, 1'b0);
      afterRise();
      check("shr_acc_L", 64'(acc_L), 64'hFF_FFFF_FFFC);
      @(negedge Sclk);
      setL(1'b1, 3'b111, 40'h12345, 1'b0);
      #1;
      check("nop_gnt_L", 64'(gnt_L), 64'h1);
      afterRise();
      check("nop_acc_L", 64'(acc_L), 64'hFF_FFFF_FFFC);

      // A single right grant moves the pointer back to L.
      @(negedge Sclk);
      setL(1'b0, OP_NOP, '0, 1'b0);
      setR(1'b1, OP_NOP, '0, 1'b0);

      // Locked left burst against a waiting right channel: 16 L grants, then R.
      @(negedge Sclk);
      setL(1'b1, OP_NOP, '0, 1'b1);
      setR(1'b1, OP_NOP, '0, 1'b0);
      for (int i = 1; i <= 17; i++) begin
         if (i > 1) @(negedge Sclk);
         #1;
         check($sformatf("burst%0d_gnt_L", i), 64'(gnt_L), (i <= 16) ? 64'h1 : 64'h0);
         check($sformatf("burst%0d_gnt_R", i), 64'(gnt_R), (i <= 16) ? 64'h0 : 64'h1);
         if (i >= 2) check($sformatf("burst%0d_owner", i), 64'(owner), 64'h1);
      end

      // Back to IDLE with pointer=L, so L restarts a burst.
      @(negedge Sclk);
      #1;
      check("rearb_owner", 64'(owner), 64'h0);
      check("rearb_gnt_L", 64'(gnt_L), 64'h1);
      @(negedge Sclk);
      #1;
      check("reburst_owner", 64'(owner), 64'h1);
      check("reburst_gnt_L", 64'(gnt_L), 64'h1);

      // Reset mid-burst with both requests high.
      #1;
      Reset_n = 1'b0;
      #1;
      check("midrst_gnt_L", 64'(gnt_L), 64'h0);
      check("midrst_gnt_R", 64'(gnt_R), 64'h0);
      check("midrst_owner", 64'(owner), 64'h0);
      check("midrst_acc_L", 64'(acc_L), 64'h0);
      afterRise();
      check("midrst_hold_gnt_L", 64'(gnt_L), 64'h0);

      @(negedge Sclk);
      Reset_n = 1'b1;
      setL(1'b1, OP_LOAD, 40'h123, 1'b1);
      #1;
      check("postrst_gnt_L", 64'(gnt_L), 64'h1);
      check("postrst_gnt_R", 64'(gnt_R), 64'h0);
      afterRise();
      check("postrst_acc_L", 64'(acc_L), 64'h123);
      check("postrst_owner", 64'(owner), 64'h1);

      // Clear while owned and both requesting.
      @(negedge Sclk);
      Clear = 1'b1;
      setL(1'b1, OP_NOP, '0, 1'b1);
      #1;
      check("clr2_gnt_L", 64'(gnt_L), 64'h0);
      check("clr2_gnt_R", 64'(gnt_R), 64'h0);
      afterRise();
      check("clr2_acc_L", 64'(acc_L), 64'h0);
      check("clr2_owner", 64'(owner), 64'h0);
      @(negedge Sclk);
      Clear = 1'b0;
      #1;
      check("postclr_gnt_L", 64'(gnt_L), 64'h1);
      afterRise();
      check("postclr_owner", 64'(owner), 64'h1);

      // Owner drops its request: the other side is served in the same cycle.
      @(negedge Sclk);
      setL(1'b0, OP_NOP, '0, 1'b0);
      #1;
      check("drop_gnt_L", 64'(gnt_L), 64'h0);
      check("drop_gnt_R", 64'(gnt_R), 64'h1);
      afterRise();
      check("drop_owner", 64'(owner), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Time-multiplexes one 40-bit adder/shift-accumulator datapath between the left and right ALU sequencers. This lets a reduced-area MSDAP build use one arithmetic unit instead of two per-channel adder/shifter pairs. The block holds one accumulator context per channel, arbitrates round-robin and supports locked bursts, with a starvation limit on each burst. It sits between the per-channel sequencers and the PISO output stage, which reads acc_L/acc_R directly.

Parameters:
WIDTH, 40, accumulator and operand width (two's complement)
MAX_BURST, 16, maximum consecutive locked grants to one channel while the other channel waits
CNT_W, 5, burst counter width; must hold MAX_BURST

Ports:
Sclk  input  1  system clock; all state changes on the rising edge
Reset_n  input  1  asynchronous, active-low reset
Clear  input  1  synchronous clear of both contexts and the arbiter state
req_L  input  1  left request; op_L, opnd_L and lock_L are held stable while req_L=1
op_L  input  3  left opcode
opnd_L  input  WIDTH  left operand
lock_L  input  1  keep ownership after this op
req_R, op_R, opnd_R, lock_R  input  1/3/WIDTH/1  right-channel equivalents
gnt_L  output  1  combinational; the left op is consumed at this clock edge
gnt_R  output  1  combinational; the right op is consumed at this clock edge
acc_L  output  WIDTH  left accumulator (registered)
acc_R  output  WIDTH  right accumulator (registered)
ovf_L  output  1  sticky signed-overflow flag, left
ovf_R  output  1  sticky signed-overflow flag, right
owner  output  2  00 IDLE, 01 OWN_L, 10 OWN_R

Behaviour:
- Reset (async, Reset_n=0):
  - acc_L=acc_R=0, ovf_L=ovf_R=0.
  - State IDLE, priority pointer=L, burst count=0.
  - gnt_L=gnt_R=0 while in reset.
- Clear=1: same effect as reset on the next edge. Both grants are forced to 0 that cycle. Clear wins over any request.
- Grants:
  - At most one grant per cycle; gnt_L and gnt_R are never both 1.
  - A granted op updates its channel's accumulator at that edge. The result is visible on acc_X the following cycle.
  - A request held high across cycles is consumed once per granted cycle. The sequencer must change or drop the request after each gnt.
- Opcodes (applied to the granted channel X only):
  - 000 ADD: acc=acc+opnd.
  - 001 SUB: acc=acc-opnd.
  - 010 SHR: arithmetic right shift by 1 (sign bit kept).
  - 011 CLR: acc=0 and ovf_X=0.
  - 100 LOAD: acc=opnd.
  - 101-111 NOP: granted, no state change.
- Arithmetic:
  - Results wrap modulo 2^WIDTH; there is no saturation.
  - ovf_X sets on ADD/SUB when the effective operands have the same sign and the result sign differs.
  - ovf_X is cleared only by CLR, Clear or reset.
- IDLE:
  - Only one channel requesting: that channel is granted.
  - Both requesting: the channel named by the priority pointer is granted.
  - After any grant the pointer moves to the other channel.
  - If the granted channel has lock=1: next state is OWN_X with count=1. Otherwise the state stays IDLE.
- OWN_X:
  - If req_X=1 and no forced release applies: X is granted. Count increments, saturating at MAX_BURST.
  - lock_X=0 on a granted op: state returns to IDLE after that op.
  - req_X=0: ownership drops in the same cycle. The other channel may be granted that cycle under IDLE rules, and the next state is taken from that decision.
  - Forced release: count==MAX_BURST and the other channel requesting. X is not granted; the other channel is granted under IDLE rules with the pointer set to it. The next state is IDLE, or OWN_other if its lock=1.
  - count==MAX_BURST and the other channel not requesting: X keeps being granted and the count stays saturated.
- Burst count: reset to 0 on entering IDLE.
- Reset mid-burst: ownership is lost and pending requests are re-arbitrated from IDLE with pointer=L.

Test Plan:
- Reset, then req_L with LOAD 0x00_0001_0000, then ADD 0x00_0002_0000 -> gnt_L in the same cycles; acc_L=0x00_0003_0000 one cycle after the second grant; acc_R stays 0.
- req_L and req_R held together with NOP, no lock, 6 cycles -> grants alternate L,R,L,R,L,R; never both high.
- acc_R=0x7F_FFFF_FFFF then ADD 1 -> acc_R=0x80_0000_0000 and ovf_R=1; a following CLR -> acc_R=0 and ovf_R=0.
- acc_L=0xFF_FFFF_FFF8 then SHR -> 0xFF_FFFF_FFFC (sign preserved).
- L locked burst with req_R also held -> exactly 16 consecutive gnt_L, then gnt_R on the 17th cycle; owner reads 01 throughout the burst.
- Reset_n pulsed low mid-burst and Clear asserted with both requests high -> all outputs 0 and owner=00. After release the first grant goes to L.
